// File: rtl/histogram_eq_top.sv
// histogram_eq_top: 8-bit greyscale histogram-equalisation engine.
// A start pulse runs CLEAR -> HIST -> HWRITE -> MAP -> FIN. HIST builds a
// 256-bin histogram from input_mem. HWRITE streams the bins to scratch_mem
// four per 128-bit word while building the CDF. MAP writes the equalised
// image to output_mem, which is read back through out_raddr/out_rdata.
// Optional build macro HIST_CLAMP_EN: when defined, the mapped value saturates
// at 255; when undefined, it keeps only its low 8 bits.
module histogram_eq_top #(
  parameter int LOG2_PIXELS = 16,
  parameter int MEM_AW      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [MEM_AW:0]   input_mem_depth,
  input  logic [MEM_AW:0]   scratch_mem_depth,
  input  logic [MEM_AW:0]   output_mem_depth,
  input  logic              new_image_pulse,
  input  logic [MEM_AW-1:0] out_raddr,
  output logic [7:0]        out_rdata,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = 2 ** MEM_AW;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_HIST,
    ST_HWRITE,
    ST_MAP,
    ST_FIN
  } state_e;

  // Control state
  state_e          state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [MEM_AW:0] cnt_q;

  // NOTE: the three memories are never reset. They map to RAM macros, which
  // have no reset, and whatever a run wrote before an abort must survive.
  // The bins and the CDF accumulator are flops and are cleared.
  logic [7:0]   input_mem   [DEPTH];
  logic [127:0] scratch_mem [DEPTH];
  logic [7:0]   output_mem  [DEPTH];

  // Histogram and CDF storage
  logic [31:0] bin_q [256];
  logic [31:0] cdf_q [256];
  logic [31:0] acc_q;

  // Input memory read pipeline, shared by HIST and MAP
  logic              rd_issue;
  logic [MEM_AW-1:0] rd_addr;
  logic              rd_valid_q;
  logic [MEM_AW-1:0] rd_idx_q;
  logic [7:0]        rd_data_q;

  // Scratch write port, kept as named nets so it can be observed
  logic              hist_we;
  logic [MEM_AW-1:0] hist_waddr;
  logic [127:0]      hist_wdata;

  // HWRITE datapath
  logic [5:0]  hw_k;
  logic [31:0] hw_bin [4];
  logic [31:0] hw_sum [4];

  // MAP datapath
  logic [39:0] map_prod;
  logic [7:0]  map_v;
  logic        out_we;
  logic [7:0]  out_rdata_q;
`ifdef HIST_CLAMP_EN
  logic [39:0] map_shift;
`endif

  assign hw_k    = cnt_q[5:0];
  assign rd_addr = cnt_q[MEM_AW-1:0];

  // FSM: state register with the registered status outputs
  // NOTE: all clocked state uses non-blocking assignments, so every register
  // sees pre-edge values and the process order does not matter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // FSM: next-state logic; the start pulse is only looked at in IDLE
  // NOTE: state_d gets a default before the case, so every path assigns it
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (new_image_pulse) state_d = ST_CLEAR;
      ST_CLEAR:  state_d = ST_HIST;
      ST_HIST:   if (cnt_q >= input_mem_depth) state_d = ST_HWRITE;
      ST_HWRITE: if (hw_k == 6'd63) state_d = ST_MAP;
      ST_MAP:    if (cnt_q >= input_mem_depth) state_d = ST_FIN;
      ST_FIN:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs and strobes derived from the state
  always_comb begin
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_FIN);
    hist_we  = (state_q == ST_HWRITE) &&
               ((MEM_AW + 1)'(hw_k) < scratch_mem_depth);
    rd_issue = ((state_q == ST_HIST) || (state_q == ST_MAP)) &&
               (cnt_q < input_mem_depth);
  end

  // Phase counter: restarts at 0 on every state change and is held in IDLE
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if ((state_d != state_q) || (state_q == ST_IDLE)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Input memory synchronous read, one cycle of latency
  always_ff @(posedge clock) begin
    rd_data_q <= input_mem[rd_addr];
  end

  // Tag for the pixel returning next cycle: whether it is valid, and its index
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_idx_q   <= '0;
    end else begin
      rd_valid_q <= rd_issue;
      rd_idx_q   <= rd_addr;
    end
  end

  // Histogram bins: cleared in CLEAR, bumped by each pixel returned in HIST
  always_ff @(posedge clock) begin
    if (reset || (state_q == ST_CLEAR)) begin
      for (int b = 0; b < 256; b++) begin
        bin_q[b] <= '0;
      end
    end else if ((state_q == ST_HIST) && rd_valid_q) begin
      bin_q[rd_data_q] <= bin_q[rd_data_q] + 32'd1;
    end
  end

  // HWRITE: select four bins and form their running sums on top of the accumulator
  always_comb begin
    logic [31:0] run;
    run = acc_q;
    for (int j = 0; j < 4; j++) begin
      hw_bin[j] = bin_q[{hw_k, 2'(j)}];
      run       = run + hw_bin[j];
      hw_sum[j] = run;
    end
    hist_wdata = {hw_bin[3], hw_bin[2], hw_bin[1], hw_bin[0]};
    hist_waddr = MEM_AW'(hw_k);
  end

  // CDF accumulator: zeroed in CLEAR, advances by one 4-bin group per HWRITE cycle
  always_ff @(posedge clock) begin
    if (reset || (state_q == ST_CLEAR)) begin
      acc_q <= '0;
    end else if (state_q == ST_HWRITE) begin
      acc_q <= hw_sum[3];
    end
  end

  // CDF table: filled four entries per HWRITE cycle; every entry is rewritten
  // each run, so it needs no clear
  always_ff @(posedge clock) begin
    if (state_q == ST_HWRITE) begin
      for (int j = 0; j < 4; j++) begin
        cdf_q[{hw_k, 2'(j)}] <= hw_sum[j];
      end
    end
  end

  // Scratch write; dropped in a reset cycle so an abort stops writes at once
  always_ff @(posedge clock) begin
    if (hist_we && !reset) begin
      scratch_mem[hist_waddr] <= hist_wdata;
    end
  end

  // MAP: scale the CDF of the returned pixel to 0..255 and qualify the write
  always_comb begin
    map_prod = 40'(cdf_q[rd_data_q]) * 40'd255;
`ifdef HIST_CLAMP_EN
    map_shift = map_prod >> LOG2_PIXELS;
    map_v     = (map_shift > 40'd255) ? 8'hFF : map_shift[7:0];
`else
    map_v     = 8'(map_prod >> LOG2_PIXELS);
`endif
    out_we   = (state_q == ST_MAP) && rd_valid_q &&
               ((MEM_AW + 1)'(rd_idx_q) < output_mem_depth);
  end

  // Output memory write port
  always_ff @(posedge clock) begin
    if (out_we && !reset) begin
      output_mem[rd_idx_q] <= map_v;
    end
  end

  // Output memory debug read port: registered, one cycle of latency
  always_ff @(posedge clock) begin
    if (reset) begin
      out_rdata_q <= '0;
    end else begin
      out_rdata_q <= output_mem[out_raddr];
    end
  end

  assign out_rdata = out_rdata_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_histogram_eq_top.sv
// Testbench for histogram_eq_top. It runs frames of random and patterned
// pixels and compares the scratch writes, done latency and output image
// against a behavioural model: a plain histogram, a prefix-sum CDF and a
// scaling formula. LOG2_PIXELS is reduced so that full-scale frames stay short.
module tb_histogram_eq_top;

  localparam int L  = 10;
  localparam int AW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW:0]   input_mem_depth   = '0;
  logic [AW:0]   scratch_mem_depth = '0;
  logic [AW:0]   output_mem_depth  = '0;
  logic          new_image_pulse   = 1'b0;
  logic [AW-1:0] out_raddr         = '0;
  logic [7:0]    out_rdata;
  logic          busy;
  logic          done;

  always #5 clock = ~clock;

  histogram_eq_top #(.LOG2_PIXELS(L), .MEM_AW(AW)) dut (
    .clock             (clock),
    .reset             (reset),
    .input_mem_depth   (input_mem_depth),
    .scratch_mem_depth (scratch_mem_depth),
    .output_mem_depth  (output_mem_depth),
    .new_image_pulse   (new_image_pulse),
    .out_raddr         (out_raddr),
    .out_rdata         (out_rdata),
    .busy              (busy),
    .done              (done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]   pix_m     [65536];
  int unsigned  bins_m    [256];
  int unsigned  cdf_m     [256];
  logic [7:0]   out_m     [65536];
  bit           out_known [65536];
  logic [15:0]  cap_addr  [$];
  logic [127:0] cap_data  [$];

  function automatic logic [7:0] eq_value(input int unsigned c);
    longint unsigned s;
    s = (64'(c) * 64'd255) >> L;
`ifdef HIST_CLAMP_EN
    if (s > 64'd255) s = 64'd255;
`endif
    return s[7:0];
  endfunction

  task automatic fill_pixels(input int pattern, input int d);
    for (int i = 0; i < d; i++) begin
      case (pattern)
        0:       pix_m[i] = 8'd0;
        1:       pix_m[i] = 8'(i % 256);
        2:       pix_m[i] = 8'd7;
        default: pix_m[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                        : 8'($urandom_range(40, 90));
      endcase
      dut.input_mem[i] = pix_m[i];
    end
  endtask

  task automatic build_model(input int d, input int od);
    int unsigned run;
    for (int b = 0; b < 256; b++) bins_m[b] = 0;
    for (int i = 0; i < d; i++) bins_m[pix_m[i]]++;
    run = 0;
    for (int b = 0; b < 256; b++) begin
      run      = run + bins_m[b];
      cdf_m[b] = run;
    end
    for (int i = 0; i < d && i < od; i++) begin
      out_m[i]     = eq_value(cdf_m[pix_m[i]]);
      out_known[i] = 1'b1;
    end
  endtask

  // Start one frame; capture scratch writes until done or the cycle budget runs out
  task automatic do_run(input int d, input int sd, input int od, input int repulse_at,
                        output int lat, output bit timed_out, output bit busy1);
    input_mem_depth   = 17'(d);
    scratch_mem_depth = 17'(sd);
    output_mem_depth  = 17'(od);
    cap_addr.delete();
    cap_data.delete();
    lat       = 0;
    timed_out = 1'b1;
    busy1     = 1'b0;
    @(negedge clock);
    new_image_pulse = 1'b1;
    for (int n = 1; n <= 2 * d + 68 + 40; n++) begin
      @(posedge clock);
      #1;
      new_image_pulse = (n == repulse_at);
      if (n == 1) busy1 = busy;
      if (dut.hist_we) begin
        cap_addr.push_back(dut.hist_waddr);
        cap_data.push_back(dut.hist_wdata);
      end
      if (done) begin
        lat       = n;
        timed_out = 1'b0;
        break;
      end
    end
    new_image_pulse = 1'b0;
  endtask

  task automatic read_out(input int a, output logic [7:0] v);
    @(negedge clock);
    out_raddr = 16'(a);
    @(posedge clock);
    #1;
    v = out_rdata;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
    checks++; if (out_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %0h expected 0", out_rdata); end
    checks++; if (dut.hist_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b expected 0", dut.hist_we); end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_frame(input string name, input int pattern, input int d,
                            input int sd, input int od);
    int lat, exp_n, rb;
    bit to, busy1;
    logic [127:0] exp_w;
    logic [7:0] v;
    fill_pixels(pattern, d);
    build_model(d, od);
    do_run(d, sd, od, 0, lat, to, busy1);
    checks++; if (to) begin errors++; $display("FAIL %s done_timeout: got none expected done", name); end
    checks++; if (lat != 2 * d + 68) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, 2 * d + 68); end
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL %s busy_start: got %0b expected 1", name, busy1); end
    exp_n = (sd < 64) ? sd : 64;
    checks++;
    if (cap_addr.size() != exp_n) begin
      errors++; $display("FAIL %s write_count: got %0d expected %0d", name, cap_addr.size(), exp_n);
    end
    for (int k = 0; k < cap_addr.size() && k < 64; k++) begin
      exp_w = {32'(bins_m[4*k+3]), 32'(bins_m[4*k+2]), 32'(bins_m[4*k+1]), 32'(bins_m[4*k])};
      checks++;
      if (cap_addr[k] !== 16'(k) || cap_data[k] !== exp_w) begin
        errors++;
        $display("FAIL %s scratch_%0d: got addr %0d data %032h expected addr %0d data %032h",
                 name, k, cap_addr[k], cap_data[k], k, exp_w);
      end
    end
    @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL %s end_status: got busy %0b done %0b expected 0 0", name, busy, done);
    end
    rb = (d > 64) ? d : 64;
    for (int i = 0; i < rb; i++) begin
      if (out_known[i]) begin
        read_out(i, v);
        checks++;
        if (v !== out_m[i]) begin
          errors++; $display("FAIL %s out_%0d: got %0h expected %0h", name, i, v, out_m[i]);
        end
      end
    end
  endtask

  task automatic test_restart_ignored();
    int lat, dones;
    bit to, busy1;
    fill_pixels(3, 200);
    build_model(200, 65536);
    do_run(200, 64, 65536, 5, lat, to, busy1);
    checks++; if (to) begin errors++; $display("FAIL restart done_timeout: got none expected done"); end
    checks++; if (lat != 468) begin errors++; $display("FAIL restart latency: got %0d expected 468", lat); end
    checks++; if (cap_addr.size() != 64) begin errors++; $display("FAIL restart write_count: got %0d expected 64", cap_addr.size()); end
    dones = 0;
    repeat (100) begin
      @(posedge clock);
      #1;
      if (done || busy) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL restart extra_activity: got %0d cycles expected 0", dones); end
  endtask

  task automatic test_reset_mid_hwrite();
    bit found;
    int stray;
    fill_pixels(3, 200);
    input_mem_depth   = 17'd200;
    scratch_mem_depth = 17'd64;
    output_mem_depth  = 17'd65536;
    found = 1'b0;
    @(negedge clock);
    new_image_pulse = 1'b1;
    for (int n = 1; n <= 600; n++) begin
      @(posedge clock);
      #1;
      new_image_pulse = 1'b0;
      if (dut.hist_we) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL abort reach_hwrite: got none expected hist_we"); end
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort busy: got %0b expected 0", busy); end
    checks++; if (dut.hist_we !== 1'b0) begin errors++; $display("FAIL abort we: got %0b expected 0", dut.hist_we); end
    checks++; if (out_rdata !== 8'h00) begin errors++; $display("FAIL abort rdata: got %0h expected 0", out_rdata); end
    @(negedge clock);
    reset = 1'b0;
    stray = 0;
    repeat (100) begin
      @(posedge clock);
      #1;
      if (dut.hist_we || done || busy) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL abort stray_activity: got %0d cycles expected 0", stray); end
  endtask

  initial begin
    test_reset();
    test_frame("all_zero", 0, 1024, 64, 65536);
    test_frame("ramp", 1, 1024, 64, 65536);
    test_frame("sevens", 2, 4, 64, 65536);
    test_frame("scratch_limit", 3, 300, 10, 65536);
    test_frame("zero_depth", 0, 0, 64, 65536);
    test_frame("random_a", 3, 1500, 40, 900);
    test_frame("back_to_back", 3, 1500, 64, 1500);
    test_restart_ignored();
    test_reset_mid_hwrite();
    test_frame("after_abort", 3, 700, 64, 600);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
